// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: shared state encoding, defaults and state decodes for the debouncer
package input_debouncer_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} statetype;
  function automatic logic level_of(statetype s);
    return s == STABLE_HI || s == PEND_LO;
  endfunction
  function automatic logic is_pend(statetype s);
    return s == PEND_HI || s == PEND_LO;
  endfunction
endpackage

// File: rtl/input_debouncer_sync.sv
// input_debouncer_sync: generic two-flop synchronizer without reset
module input_debouncer_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_q;
  // two back-to-back flops absorb metastability on the asynchronous input
  always_ff @(posedge clk) begin
    r_meta <= i_d;
    r_q    <= r_meta;
  end
  assign o_q = r_q;
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a raw level and only follows it after it has been stable long enough
module input_debouncer import input_debouncer_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             din,
  input  logic             en,
  input  logic [CNT_W-1:0] threshold,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             busy
);
  statetype         r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [1:0]       r_warm;
  logic             r_dout, r_rise, r_fall, r_busy;
  logic             w_s, w_rise, w_fall;

  input_debouncer_sync #(.W(1)) u_sync (.clk(clk), .i_d(din), .o_q(w_s));

  // warm-up counter keeps the FSM idle until the unreset synchronizer holds real data
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_warm <= 2'd0;
    else if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;

  // next-state logic; the edge right after a pulse is skipped so pulses can never be adjacent
  always_comb begin
    w_state = r_state;
    w_cnt   = '0;
    w_rise  = 1'b0;
    w_fall  = 1'b0;
    if (!en) w_state = level_of(r_state) ? STABLE_HI : STABLE_LO;
    else if (r_warm == 2'd2 && !r_rise && !r_fall) begin
      case (r_state)
        STABLE_LO:
          if (w_s) begin
            if (threshold == '0) begin
              w_state = STABLE_HI;
              w_rise  = 1'b1;
            end else begin
              w_state = PEND_HI;
              w_cnt   = CNT_W'(1);
            end
          end
        PEND_HI:
          if (!w_s) w_state = STABLE_LO;
          else if (r_cnt >= threshold) begin
            w_state = STABLE_HI;
            w_rise  = 1'b1;
          end else w_cnt = &r_cnt ? r_cnt : r_cnt + 1'b1;
        STABLE_HI:
          if (!w_s) begin
            if (threshold == '0) begin
              w_state = STABLE_LO;
              w_fall  = 1'b1;
            end else begin
              w_state = PEND_LO;
              w_cnt   = CNT_W'(1);
            end
          end
        PEND_LO:
          if (w_s) w_state = STABLE_HI;
          else if (r_cnt >= threshold) begin
            w_state = STABLE_LO;
            w_fall  = 1'b1;
          end else w_cnt = &r_cnt ? r_cnt : r_cnt + 1'b1;
        default: w_state = STABLE_LO;
      endcase
    end
  end

  // state, counter and every output are registered from the next-state values
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_dout  <= level_of(w_state);
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_busy  <= is_pend(w_state);
    end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;
endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001: Parameter CNT_W, default 16, is the width of the debounce counter and of the threshold.
REQ-002: Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003: Port resetn, input, 1 bit, is the reset; it is asynchronous and active-low.
REQ-004: Port din, input, 1 bit, is the raw asynchronous level, for example a GPIO pin or UART RX line.
REQ-005: Port en, input, 1 bit, enables filtering.
REQ-006: Port threshold, input, CNT_W bits, sets the number of extra consecutive stable cycles required before dout changes.
REQ-007: Port dout, output, 1 bit, is the debounced level, driven from a register.
REQ-008: Port rise, output, 1 bit, is a one-cycle pulse on the cycle dout goes 0 to 1.
REQ-009: Port fall, output, 1 bit, is a one-cycle pulse on the cycle dout goes 1 to 0.
REQ-010: Port busy, output, 1 bit, is high while in a pending state.

Function
REQ-011: din shall pass through a two-flop synchronizer; the FSM only ever samples the synchronized value s.
REQ-012: The FSM shall have states STABLE_LO, PEND_HI, STABLE_HI and PEND_LO; dout is 1 only in STABLE_HI and PEND_LO.
REQ-013: In STABLE_LO with s=1 and threshold=0, the FSM shall go to STABLE_HI, set dout=1 and pulse rise.
REQ-014: In STABLE_LO with s=1 and threshold≠0, the FSM shall go to PEND_HI with cnt=1.
REQ-015: In PEND_HI with s=1 and cnt≥threshold, the FSM shall go to STABLE_HI, set dout=1, pulse rise and clear cnt; otherwise it increments cnt.
REQ-016: In PEND_HI with s=0, the FSM shall return to STABLE_LO with cnt=0 and no pulse.
REQ-017: STABLE_HI and PEND_LO shall mirror REQ-013 to REQ-016 with s and dout inverted, and fall in place of rise.
REQ-018: cnt shall be compared against the live threshold every cycle; lowering threshold mid-pend may complete the transition on the next edge.
REQ-019: cnt shall saturate at all-ones and never wrap.
REQ-020: Latency shall be threshold+2 edges: with raw din stable from edge e, dout and the pulse appear after edge e+2+threshold.
REQ-021: With en=0, dout shall hold, any PEND state shall return to the STABLE state matching dout, cnt shall be 0 and there shall be no pulses.
REQ-022: When en rises, evaluation shall restart from the STABLE state.
REQ-023: rise and fall shall never be asserted in the same cycle, nor in two consecutive cycles.

Reset
REQ-024: On resetn low, the block shall immediately go to STABLE_LO with cnt=0, dout=0, rise=0, fall=0 and busy=0.
REQ-025: Synchronizer flops have no reset; a 2-bit warm-up counter, cleared by reset, shall block FSM transitions for the first 2 edges after resetn deasserts.
REQ-026: Reset asserted mid-pend shall abort without any pulse.

Structure
REQ-027: The state enum statetype (STABLE_LO, PEND_HI, STABLE_HI, PEND_LO) shall live in a shared package; the CNT_W default shall live there as a constant.
REQ-028: There shall be exactly one sub-module: the existing generic synchronizer instance on din.
REQ-029: All outputs shall be registered; the block has no combinational path from din to any output.

Verification
REQ-030: Reset release with din=1 and threshold=3 -> dout stays 0 for 2 warm-up edges, then rises 5 edges after the first sampled edge, with one rise pulse.
REQ-031: threshold=4 with din glitching high for 3 cycles -> busy is high for 3 cycles, then dout stays 0 with no pulse.
REQ-032: threshold=0 and din toggles -> dout follows exactly 2 edges later, with rise and fall alternating and never adjacent.
REQ-033: threshold=10 during PEND_HI with cnt=6, then threshold set to 2 -> transition and rise on the next edge.
REQ-034: en dropped mid-PEND_LO -> dout holds 1, busy falls next edge, cnt=0 and there is no fall pulse.
REQ-035: resetn asserted asynchronously mid-PEND_HI -> all outputs are 0 before the next clock edge.
